// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU phase controller: FSM encoding, phase indices,
// opcode values and the one-hot test used on the sequencer phase lines.
package alu_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_START = 2'd1;
  localparam state_t S_RUN   = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam int unsigned NPH = 6;

  localparam logic [2:0] PH_LDA = 3'd0;
  localparam logic [2:0] PH_LDB = 3'd1;
  localparam logic [2:0] PH_EX1 = 3'd2;
  localparam logic [2:0] PH_EX2 = 3'd3;
  localparam logic [2:0] PH_WR  = 3'd4;
  localparam logic [2:0] PH_FLG = 3'd5;

  // Only this opcode uses the second execute phase.
  localparam int unsigned OP_TWO_EXEC = 0;
  localparam int unsigned OP_ADD      = 1;
  localparam int unsigned OP_SUB      = 2;
  localparam int unsigned OP_AND      = 3;

  function automatic logic onehot6(input logic [5:0] v);
    return (v != '0) && ((v & (v - 6'd1)) == '0);
  endfunction

endpackage

// File: rtl/phase_onehot_chk.sv
// Registers the sequencer phase lines, decodes the phase index and flags
// two consecutive non-one-hot samples taken while the check is enabled.
module phase_onehot_chk
  import alu_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       Clr,
  input  logic       run_i,
  input  logic [5:0] fi_i,
  output logic [2:0] ph_o,
  output logic       ph_ok_o,
  output logic       wrap_o,
  output logic       bad2_o
);

  logic [5:0] fi_q;
  logic       badprev_q;

  always_ff @(posedge CLK or posedge Clr) begin
    if (Clr) begin
      fi_q      <= '0;
      badprev_q <= 1'b0;
    end else begin
      fi_q      <= fi_i;
      badprev_q <= run_i & ~ph_ok_o;
    end
  end

  assign ph_ok_o = onehot6(fi_q);

  always_comb begin
    ph_o = '0;
    for (int unsigned k = 0; k < NPH; k++) begin
      if (fi_q[k]) ph_o = 3'(k);
    end
  end

  // Wrap is seen on the edge where fi_q moves from phase 5 to phase 0.
  assign wrap_o = ph_ok_o && (ph_o == PH_FLG) && (fi_i == 6'b000001);
  assign bad2_o = run_i & ~ph_ok_o & badprev_q;

endmodule

// File: rtl/alu_phase_ctrl.sv
// Master for the 6-phase sequencer: starts it, decodes phases into ALU
// micro-op enables, counts rounds and stops it after the programmed count.
module alu_phase_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 2,
  parameter int unsigned CW  = 4
) (
  input  logic           CLK,
  input  logic           Clr,
  input  logic           req,
  input  logic [OPW-1:0] op,
  input  logic [CW-1:0]  rounds,
  input  logic [5:0]     fi,
  output logic           BGN,
  output logic           SRST,
  output logic           END,
  output logic           ld_a,
  output logic           ld_b,
  output logic           exec,
  output logic           wr_res,
  output logic           upd_flags,
  output logic           busy,
  output logic           ack,
  output logic           err,
  output logic [CW-1:0]  round_cnt
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [CW-1:0]  rounds_q, rounds_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           end_q, end_d;

  logic [2:0] ph;
  logic       ph_ok, wrap, bad2, in_run, stop, en;

  assign in_run = (state_q == S_RUN);

  phase_onehot_chk u_chk (
    .CLK     (CLK),
    .Clr     (Clr),
    .run_i   (in_run),
    .fi_i    (fi),
    .ph_o    (ph),
    .ph_ok_o (ph_ok),
    .wrap_o  (wrap),
    .bad2_o  (bad2)
  );

  assign en   = in_run & ph_ok;
  assign stop = en && (ph == PH_FLG) && (cnt_q == rounds_q - CW'(1));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rounds_d = rounds_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    end_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d     = op;
          rounds_d = (rounds == '0) ? CW'(1) : rounds;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (bad2) begin
          err_d   = 1'b1;
          end_d   = 1'b1;
          state_d = S_DONE;
        end else if (stop) begin
          end_d   = 1'b1;
          state_d = S_DONE;
        end else if (wrap && (cnt_q != '1)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Clr) begin
    if (Clr) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rounds_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rounds_q <= rounds_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      end_q    <= end_d;
    end
  end

  assign BGN       = (state_q == S_START);
  assign SRST      = (state_q == S_START);
  assign END       = Clr | end_q;
  assign busy      = (state_q != S_IDLE);
  assign ack       = (state_q == S_DONE);
  assign err       = err_q;
  assign round_cnt = cnt_q;

  assign ld_a      = en && (ph == PH_LDA);
  assign ld_b      = en && (ph == PH_LDB);
  assign exec      = en && ((ph == PH_EX1) ||
                            ((ph == PH_EX2) && (op_q == OPW'(OP_TWO_EXEC))));
  assign wr_res    = en && (ph == PH_WR);
  assign upd_flags = en && (ph == PH_FLG);

endmodule

// File: tb/tb_alu_phase_ctrl.sv
// Scoreboard bench for alu_phase_ctrl driven by an ideal 6-phase sequencer
// model with optional dropped phase samples.
module tb_alu_phase_ctrl;

  logic       CLK = 1'b0;
  logic       Clr = 1'b1;
  logic       req = 1'b0;
  logic [1:0] op = '0;
  logic [3:0] rounds = '0;
  logic [5:0] fi;
  logic       BGN, SRST, END, ld_a, ld_b, exec, wr_res, upd_flags, busy, ack, err;
  logic [3:0] round_cnt;

  alu_phase_ctrl #(.OPW(2), .CW(4)) dut (
    .CLK(CLK), .Clr(Clr), .req(req), .op(op), .rounds(rounds), .fi(fi),
    .BGN(BGN), .SRST(SRST), .END(END), .ld_a(ld_a), .ld_b(ld_b), .exec(exec),
    .wr_res(wr_res), .upd_flags(upd_flags), .busy(busy), .ack(ack), .err(err),
    .round_cnt(round_cnt)
  );

  always #5 CLK = ~CLK;

  localparam logic [10:0] E_BGN = 11'h400, E_SRST = 11'h200, E_LDA = 11'h100;
  localparam logic [10:0] E_LDB = 11'h080, E_EXE = 11'h040, E_WR = 11'h020;
  localparam logic [10:0] E_FLG = 11'h010, E_ACK = 11'h008, E_END = 11'h004;
  localparam logic [10:0] E_ERR = 11'h002, E_BSY = 11'h001;

  typedef struct packed {
    logic [10:0] sig;
    logic [3:0]  cnt;
  } ev_t;

  ev_t exp_q[$];
  int  compared = 0;
  int  failed = 0;
  logic sb_on = 1'b0;

  // Ideal sequencer: BGN/SRST start it at phase 0, END stops it.
  logic seq_run = 1'b0;
  int   ph_s = 0;
  int   s_cnt = 0;
  int   m0 = -1;
  int   m1 = -1;

  always @(posedge CLK) begin
    if (END) seq_run <= 1'b0;
    else if (BGN) begin
      seq_run <= 1'b1;
      ph_s    <= 0;
      s_cnt   <= 0;
    end else if (seq_run) begin
      ph_s  <= (ph_s == 5) ? 0 : ph_s + 1;
      s_cnt <= s_cnt + 1;
    end
  end

  assign fi = (seq_run && s_cnt != m0 && s_cnt != m1) ? (6'b000001 << ph_s) : 6'b000000;

  // Monitor: every cycle with a visible action pops one expected event.
  logic [10:0] mon_sig;
  ev_t         mon_e;
  always @(negedge CLK) begin
    if (sb_on && !Clr) begin
      mon_sig = {BGN, SRST, ld_a, ld_b, exec, wr_res, upd_flags, ack, END, err, busy};
      if (BGN | ld_a | ld_b | exec | wr_res | upd_flags | ack) begin
        compared++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_event got sig=%b rc=%0d required no event", mon_sig, round_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_sig !== mon_e.sig || round_cnt !== mon_e.cnt) begin
            failed++;
            $display("FAIL event got sig=%b rc=%0d required sig=%b rc=%0d",
                     mon_sig, round_cnt, mon_e.sig, mon_e.cnt);
          end
        end
      end else begin
        compared++;
        if (END !== 1'b0) begin
          failed++;
          $display("FAIL stray_end got END=%b required 0", END);
        end
      end
    end
  end

  task automatic push_ev(input logic [10:0] sig, input int cnt);
    ev_t e;
    e.sig = sig;
    e.cnt = 4'(cnt);
    exp_q.push_back(e);
  endtask

  // Reference: walk the phase samples in order; sample s is phase s%6 of round s/6.
  task automatic model_op(input int opv, input int r, input int ma, input int mb);
    int          nr;
    int          ph;
    int          rnd;
    logic        prev_bad;
    logic [10:0] s;
    nr = (r == 0) ? 1 : r;
    prev_bad = 1'b0;
    push_ev(E_BGN | E_SRST | E_BSY, 0);
    for (int i = 0; i < 6 * nr; i++) begin
      ph  = i % 6;
      rnd = i / 6;
      if (i == ma || i == mb) begin
        if (prev_bad) begin
          push_ev(E_ACK | E_END | E_ERR | E_BSY, rnd);
          return;
        end
        prev_bad = 1'b1;
        continue;
      end
      prev_bad = 1'b0;
      case (ph)
        0: s = E_LDA;
        1: s = E_LDB;
        2: s = E_EXE;
        3: s = (opv == 0) ? E_EXE : 11'h000;
        4: s = E_WR;
        default: s = E_FLG;
      endcase
      if (s != 11'h000) push_ev(s | E_BSY, rnd);
      if (ph == 5 && rnd == nr - 1) begin
        push_ev(E_ACK | E_END | E_BSY, nr - 1);
        return;
      end
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      failed++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end
  endtask

  task automatic wait_bgn(input int budget);
    int n = 0;
    @(negedge CLK);
    while (!BGN && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("bgn_timeout", int'(BGN), 1);
  endtask

  task automatic wait_ack(input int budget);
    int n = 0;
    @(negedge CLK);
    while (!ack && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("ack_timeout", int'(ack), 1);
  endtask

  task automatic drain_check();
    repeat (2) @(negedge CLK);
    check("queue_leftover", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_op(input int opv, input int r, input int ma, input int mb);
    m0 = ma;
    m1 = mb;
    model_op(opv, r, ma, mb);
    op     = 2'(opv);
    rounds = 4'(r);
    req    = 1'b1;
    wait_bgn(4);
    req = 1'b0;
    wait_ack(160);
    drain_check();
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, int'({BGN, SRST, ld_a, ld_b, exec, wr_res, upd_flags, busy, ack, err, round_cnt}), 0);
    check({name, "_end"}, int'(END), 1);
  endtask

  initial begin
    int nr, hits, md;
    repeat (2) @(negedge CLK);
    check_reset_outputs("reset");
    Clr = 1'b0;
    @(negedge CLK);
    check("end_after_release", int'(END), 0);
    sb_on = 1'b1;

    run_op(1, 1, -1, -1);
    check("rc_after_r1", int'(round_cnt), 0);
    run_op(0, 3, -1, -1);
    check("rc_after_r3", int'(round_cnt), 2);
    run_op(2, 0, -1, -1);
    run_op(0, 2, 3, -1);
    check("no_err_single_glitch", int'(err), 0);
    run_op(2, 2, 8, 9);
    check("err_after_double", int'(err), 1);
    run_op(3, 1, -1, -1);
    check("err_cleared", int'(err), 0);

    // Clr during phase 3 of round 2, with a new request pending across it.
    m0 = -1;
    m1 = -1;
    model_op(0, 4, -1, -1);
    op = 2'd0;
    rounds = 4'd4;
    req = 1'b1;
    wait_bgn(4);
    req = 1'b0;
    hits = 0;
    for (int i = 0; i < 100 && hits < 2; i++) begin
      @(negedge CLK);
      if (exec && round_cnt == 4'd1) hits++;
    end
    check("reach_ph3_round2", hits, 2);
    #2;
    sb_on = 1'b0;
    Clr = 1'b1;
    req = 1'b1;
    op = 2'd1;
    rounds = 4'd2;
    #1;
    check_reset_outputs("clr_mid_op");
    exp_q.delete();
    @(negedge CLK);
    check_reset_outputs("clr_held");
    model_op(1, 2, -1, -1);
    Clr = 1'b0;
    sb_on = 1'b1;
    wait_bgn(4);
    req = 1'b0;
    wait_ack(160);
    drain_check();

    // Back-to-back: req held through the first completion.
    model_op(1, 1, -1, -1);
    model_op(0, 2, -1, -1);
    op = 2'd1;
    rounds = 4'd1;
    req = 1'b1;
    wait_bgn(4);
    op = 2'd0;
    rounds = 4'd2;
    wait_ack(160);
    @(negedge CLK);
    check("b2b_idle_busy", int'(busy), 0);
    check("b2b_idle_bgn", int'(BGN), 0);
    @(negedge CLK);
    check("b2b_bgn_2cyc", int'(BGN), 1);
    req = 1'b0;
    wait_ack(160);
    drain_check();

    for (int k = 0; k < 10; k++) begin
      nr = $urandom_range(0, 5);
      md = $urandom_range(0, 2);
      if (md == 0) begin
        run_op($urandom_range(0, 3), nr, -1, -1);
      end else begin
        hits = 6 * $urandom_range(0, ((nr == 0) ? 1 : nr) - 1);
        if (md == 1) run_op($urandom_range(0, 3), nr, hits + $urandom_range(1, 4), -1);
        else begin
          hits = hits + $urandom_range(1, 3);
          run_op($urandom_range(0, 3), nr, hits, hits + 1);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "timeout");
  end

endmodule
